lcd_capture: RTL and testbench

Receiving end of the PPU pixel stream. Samples `lcd_clkena`/`lcd_data` and locates each pixel in the 160x144 frame from stream gaps, since the stream carries no sync signals. Writes every pixel into an external frame RAM through a single write port. Clears the frame RAM when the LCD is switched off.

---
 rtl/lcd_capture.sv | 189 ++++++++++++++++++
 tb/tb_lcd_capture.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
// Pixel-stream capture for the 160x144 LCD: recovers x/y from idle gaps in the
// strobe stream, writes each pixel to an external frame RAM and clears it on LCD off.
module lcd_capture #(
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 144,
    parameter int         HGAP      = 64,
    parameter int         VGAP      = 1024,
    parameter logic [1:0] CLEAR_VAL = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_on,
    input  logic        lcd_clkena,
    input  logic [1:0]  lcd_data,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [1:0]  fb_data,
    output logic        frame_done,
    output logic        busy,
    output logic [7:0]  cur_line,
    output logic        sync_err,
    output logic [1:0]  dbg_state
);

    localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);
    localparam logic [14:0] WIDTH_C   = 15'(WIDTH);
    localparam logic [10:0] VGAP_C    = 11'(VGAP);
    localparam logic [10:0] HGAP_C    = 11'(HGAP);
    localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
    localparam logic [7:0]  Y_LAST    = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [10:0] idle, idle_nx;
    logic [7:0]  x, x_nx, y, y_nx;
    logic [14:0] line_base, base_nx;
    logic [14:0] clr_addr, clr_nx;
    logic        on_q, fall;
    logic        we_nx, done_nx, busy_nx, err_set, write_px;
    logic [14:0] addr_nx, wbase;
    logic [1:0]  data_nx;
    logic [7:0]  wx, wy;

    assign dbg_state = state;

    // fb_we is a one-cycle write strobe with no back-pressure: the RAM must
    // accept fb_addr/fb_data on every cycle fb_we is high.
    always_comb begin
        fall     = on_q & ~lcd_on;
        state_nx = state;
        idle_nx  = lcd_clkena ? 11'd0 : ((idle >= VGAP_C) ? VGAP_C : idle + 11'd1);
        x_nx     = x;
        y_nx     = y;
        base_nx  = line_base;
        clr_nx   = clr_addr;
        we_nx    = 1'b0;
        addr_nx  = fb_addr;
        data_nx  = fb_data;
        done_nx  = 1'b0;
        busy_nx  = 1'b0;
        err_set  = 1'b0;
        write_px = 1'b0;
        wx       = x;
        wy       = y;
        wbase    = line_base;

        if (fall) begin
            state_nx = CLEAR;
            clr_nx   = 15'd0;
            busy_nx  = (state == CLEAR);
        end else begin
            case (state)
                SYNC: begin
                    if (lcd_clkena && lcd_on && idle >= VGAP_C) begin
                        write_px = 1'b1;
                        wx       = 8'd0;
                        wy       = 8'd0;
                        wbase    = 15'd0;
                        state_nx = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (lcd_clkena && lcd_on) begin
                        write_px = 1'b1;
                        if (idle >= VGAP_C) begin
                            err_set = (x != 8'd0) || (y != 8'd0);
                            wx      = 8'd0;
                            wy      = 8'd0;
                            wbase   = 15'd0;
                        end else if (idle >= HGAP_C && x != 8'd0) begin
                            // Truncated line: skip to the start of the next one.
                            err_set = 1'b1;
                            wx      = 8'd0;
                            if (y == Y_LAST) begin
                                wy    = 8'd0;
                                wbase = 15'd0;
                            end else begin
                                wy    = y + 8'd1;
                                wbase = line_base + WIDTH_C;
                            end
                        end else if (x == 8'd0 && y == 8'd0) begin
                            err_set = 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    we_nx   = 1'b1;
                    addr_nx = clr_addr;
                    data_nx = CLEAR_VAL;
                    busy_nx = 1'b1;
                    clr_nx  = clr_addr + 15'd1;
                    if (clr_addr == LAST_ADDR) begin
                        state_nx = SYNC;
                        idle_nx  = VGAP_C;
                        x_nx     = 8'd0;
                        y_nx     = 8'd0;
                        base_nx  = 15'd0;
                        clr_nx   = 15'd0;
                    end
                end
                default: state_nx = SYNC;
            endcase
        end

        if (write_px) begin
            we_nx   = 1'b1;
            addr_nx = wbase + {7'd0, wx};
            data_nx = lcd_data;
            if (wx == X_LAST) begin
                x_nx = 8'd0;
                if (wy == Y_LAST) begin
                    y_nx    = 8'd0;
                    base_nx = 15'd0;
                    done_nx = 1'b1;
                end else begin
                    y_nx    = wy + 8'd1;
                    base_nx = wbase + WIDTH_C;
                end
            end else begin
                x_nx    = wx + 8'd1;
                y_nx    = wy;
                base_nx = wbase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= SYNC;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle       <= VGAP_C;
            x          <= 8'd0;
            y          <= 8'd0;
            line_base  <= 15'd0;
            clr_addr   <= 15'd0;
            on_q       <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= 15'd0;
            fb_data    <= 2'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            cur_line   <= 8'd0;
            sync_err   <= 1'b0;
        end else begin
            idle       <= idle_nx;
            x          <= x_nx;
            y          <= y_nx;
            line_base  <= base_nx;
            clr_addr   <= clr_nx;
            on_q       <= lcd_on;
            fb_we      <= we_nx;
            fb_addr    <= addr_nx;
            fb_data    <= data_nx;
            frame_done <= done_nx;
            busy       <= busy_nx;
            cur_line   <= y;
            if (err_set) sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture: random pixel stream against a linear-index frame model,
// expected writes queued by the driver and consumed by a write monitor.
module tb_lcd_capture;

    localparam int         WIDTH     = 160;
    localparam int         HEIGHT    = 144;
    localparam int         HGAP      = 64;
    localparam int         VGAP      = 1024;
    localparam int         FRAME     = WIDTH * HEIGHT;
    localparam logic [1:0] CLEAR_VAL = 2'b00;

    logic        clk = 1'b0;
    logic        reset, lcd_on, lcd_clkena;
    logic [1:0]  lcd_data;
    logic        fb_we, frame_done, busy, sync_err;
    logic [14:0] fb_addr;
    logic [1:0]  fb_data;
    logic [7:0]  cur_line;
    logic [1:0]  dbg_state;

    lcd_capture #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .HGAP(HGAP), .VGAP(VGAP), .CLEAR_VAL(CLEAR_VAL)
    ) dut (
        .clk(clk), .reset(reset), .lcd_on(lcd_on), .lcd_clkena(lcd_clkena),
        .lcd_data(lcd_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_done(frame_done), .busy(busy), .cur_line(cur_line),
        .sync_err(sync_err), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: {busy, frame_done, addr, data}
    logic [18:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // reference model: linear pixel index within the frame
    int m_p;
    bit m_synced;
    bit m_err;
    int idle_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic ena, input logic [1:0] d);
        lcd_clkena = ena;
        lcd_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (idle_cnt < 100000) idle_cnt++;
            tick(1'b0, 2'd0);
        end
    endtask

    task automatic send(input logic [1:0] d);
        int  a;
        bit  done;
        a    = -1;
        done = 1'b0;
        if (!m_synced) begin
            if (idle_cnt >= VGAP) begin
                a        = 0;
                m_synced = 1'b1;
            end
        end else if (idle_cnt >= VGAP) begin
            if (m_p != 0) m_err = 1'b1;
            a = 0;
        end else if (idle_cnt >= HGAP && (m_p % WIDTH) != 0) begin
            m_err = 1'b1;
            a     = ((m_p / WIDTH + 1) * WIDTH) % FRAME;
        end else begin
            if (m_p == 0) m_err = 1'b1;
            a = m_p;
        end
        if (a >= 0) begin
            m_p = a + 1;
            if (m_p == FRAME) begin
                done = 1'b1;
                m_p  = 0;
            end
            exp_q.push_back({1'b0, done, 15'(a), d});
        end
        idle_cnt = 0;
        tick(1'b1, d);
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0 && $urandom_range(0, 15) == 0) idle($urandom_range(1, 3));
            send(2'($urandom_range(0, 3)));
        end
    endtask

    task automatic line_gap();
        if ($urandom_range(0, 7) == 0) idle($urandom_range(HGAP, 300));
        else                           idle($urandom_range(0, 3));
    endtask

    task automatic push_clear();
        for (int a = 0; a < FRAME; a++) exp_q.push_back({1'b1, 1'b0, 15'(a), CLEAR_VAL});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 2'd0);
        tick(1'b0, 2'd0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_line", cur_line, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_state", dbg_state, 0);
        exp_q.delete();
        m_p      = 0;
        m_synced = 1'b0;
        m_err    = 1'b0;
        idle_cnt = VGAP;
        reset    = 1'b0;
    endtask

    task automatic monitor();
        logic [18:0] e, got;
        forever begin
            @(negedge clk);
            if (!reset) begin
                got = {busy, frame_done, fb_addr, fb_data};
                if (fb_we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got 0x%0h expected none at %0t", got, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write", 32'(got), 32'(e));
                    end
                    if (frame_done) done_cnt++;
                end else if (frame_done) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_frame_done: got 1 expected 0 at %0t", $time);
                end
            end
        end
    endtask

    initial begin
        int cnt;
        reset      = 1'b1;
        lcd_on     = 1'b1;
        lcd_clkena = 1'b0;
        lcd_data   = 2'd0;
        fork
            monitor();
        join_none
        do_reset();

        // nominal frame
        idle(5);
        for (int l = 0; l < HEIGHT; l++) begin
            send_line(WIDTH);
            if (l == 71) begin
                idle(1);
                chk("cur_line_mid", cur_line, m_p / WIDTH);
            end
            line_gap();
        end
        idle(3);
        chk("frame_done_count", done_cnt, 1);
        chk("cur_line_wrap", cur_line, m_p / WIDTH);
        chk("nominal_sync_err", sync_err, 0);

        // second frame, then early frame start
        idle(1100);
        for (int l = 0; l < 10; l++) begin
            send_line(WIDTH);
            line_gap();
        end
        chk("frame2_sync_err", sync_err, 0);
        idle(1100);
        send(2'($urandom_range(0, 3)));
        chk("early_start_err", sync_err, 32'(m_err));
        send_line(30);

        do_reset();

        // short line 5
        idle(5);
        for (int l = 0; l < 5; l++) begin
            send_line(WIDTH);
            idle(2);
        end
        send_line(100);
        idle(296);
        send(2'($urandom_range(0, 3)));
        chk("short_line_err", sync_err, 32'(m_err));
        idle(1);
        chk("short_line_cur_line", cur_line, m_p / WIDTH);
        send_line(50);

        // LCD off mid-frame
        push_clear();
        lcd_on = 1'b0;
        tick(1'b0, 2'd0);
        chk("clear_gap_we", fb_we, 0);
        tick(1'b0, 2'd0);
        chk("clear_first_we", fb_we, 1);
        chk("clear_first_addr", fb_addr, 0);
        chk("clear_first_busy", busy, 1);
        cnt = busy ? 1 : 0;
        while (busy && cnt < 30000) begin
            if (cnt == 5000) lcd_on = 1'b1;
            tick((cnt < 22900) && ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
            if (busy) cnt++;
        end
        chk("clear_len", cnt, FRAME);
        chk("clear_end_state", dbg_state, 0);
        m_synced = 1'b0;
        m_p      = 0;
        idle_cnt = VGAP;
        send(2'($urandom_range(0, 3)));
        send_line(20);
        idle(3);
        chk("after_clear_err", sync_err, 32'(m_err));
        chk("queue_drained", exp_q.size(), 0);

        // reset during clear
        push_clear();
        lcd_on = 1'b0;
        for (int i = 0; i < 300; i++) tick(1'b0, 2'd0);
        chk("mid_clear_busy", busy, 1);
        reset = 1'b1;
        tick(1'b0, 2'd0);
        chk("rst_clear_we", fb_we, 0);
        chk("rst_clear_busy", busy, 0);
        chk("rst_clear_state", dbg_state, 0);
        exp_q.delete();
        reset = 1'b0;
        idle(3);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
